led_sequence_driver: RTL and testbench

//  Output-side counterpart of button_processor: encodes a 2-bit color code back onto the four color LEDs.
//  The controller hands over one sequence item per request (enable_led).
//  The block owns all display timing: ON time set by speed, then an inter-item OFF gap, then a done pulse.

---
 rtl/led_sequence_driver.sv | 142 ++++++++++++++
 tb/tb_led_sequence_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_sequence_driver.sv
// Drives the four color LEDs from controller requests: one-hot item display or an all-LED flash, each followed by an off gap and a done pulse.
// Optional ERROR_BLINK_EN: the flash repeats as three on/off pairs before done.
module led_sequence_driver #(
  parameter int COLOR_CODEFY_W = 2,
  parameter int FAST_ON_CYCLES = 10,
  parameter int SLOW_ON_CYCLES = 25,
  parameter int GAP_CYCLES     = 5,
  parameter int FLASH_CYCLES   = 20,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COLOR_CODEFY_W-1:0] color_in,
  input  logic                      speed,
  input  logic                      enable_led,
  input  logic                      all_leds,
  output logic                      ready,
  output logic                      done,
  output logic                      led_green,
  output logic                      led_red,
  output logic                      led_blue,
  output logic                      led_yellow
);

  typedef enum logic [1:0] {IDLE, SHOW, FLASH, GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0]       leds, leds_n;
  logic             done_r, done_n;
  logic             ready_r, ready_n;
`ifdef ERROR_BLINK_EN
  logic [1:0]       rep, rep_n;
  logic             flashing, flashing_n;
`endif

  // Every output is computed one cycle ahead and registered with the state.
  always_comb begin
    state_n = state;
    timer_n = timer;
    leds_n  = leds;
    done_n  = 1'b0;
    ready_n = 1'b0;
`ifdef ERROR_BLINK_EN
    rep_n      = rep;
    flashing_n = flashing;
`endif
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        leds_n  = '0;
        if (all_leds) begin
          state_n = FLASH;
          timer_n = CNT_W'(FLASH_CYCLES - 1);
          leds_n  = '1;
          ready_n = 1'b0;
`ifdef ERROR_BLINK_EN
          rep_n      = '0;
          flashing_n = 1'b1;
`endif
        end else if (enable_led) begin
          state_n = SHOW;
          timer_n = speed ? CNT_W'(FAST_ON_CYCLES - 1) : CNT_W'(SLOW_ON_CYCLES - 1);
          leds_n  = 4'b0001 << color_in;
          ready_n = 1'b0;
`ifdef ERROR_BLINK_EN
          flashing_n = 1'b0;
`endif
        end
      end
      SHOW, FLASH: begin
        if (timer == '0) begin
          state_n = GAP;
          timer_n = CNT_W'(GAP_CYCLES - 1);
          leds_n  = '0;
        end else begin
          timer_n = timer - CNT_W'(1);
        end
      end
      GAP: begin
        if (timer == '0) begin
`ifdef ERROR_BLINK_EN
          if (flashing && rep != 2'd2) begin
            rep_n   = rep + 2'd1;
            state_n = FLASH;
            timer_n = CNT_W'(FLASH_CYCLES - 1);
            leds_n  = '1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            ready_n = 1'b1;
          end
`else
          state_n = IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
`endif
        end else begin
          timer_n = timer - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
        leds_n  = '0;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      leds    <= '0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
`ifdef ERROR_BLINK_EN
      rep      <= '0;
      flashing <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      leds    <= leds_n;
      done_r  <= done_n;
      ready_r <= ready_n;
`ifdef ERROR_BLINK_EN
      rep      <= rep_n;
      flashing <= flashing_n;
`endif
    end
  end

  assign ready      = ready_r;
  assign done       = done_r;
  assign led_green  = leds[0];
  assign led_red    = leds[1];
  assign led_blue   = leds[2];
  assign led_yellow = leds[3];

endmodule

// File: tb/tb_led_sequence_driver.sv
// Bench for led_sequence_driver: directed scenarios plus random requests, checked every cycle
// against a per-cycle schedule of expected outputs built from the display timing rules.
module tb_led_sequence_driver;

  localparam int FAST  = 2;
  localparam int SLOW  = 4;
  localparam int GAPC  = 1;
  localparam int FLASH = 3;
`ifdef ERROR_BLINK_EN
  localparam int REPS = 3;
`else
  localparam int REPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] color_in = '0;
  logic       speed = 1'b0;
  logic       enable_led = 1'b0;
  logic       all_leds = 1'b0;
  logic       ready, done;
  logic       led_green, led_red, led_blue, led_yellow;

  led_sequence_driver #(
    .COLOR_CODEFY_W(2),
    .FAST_ON_CYCLES(FAST),
    .SLOW_ON_CYCLES(SLOW),
    .GAP_CYCLES(GAPC),
    .FLASH_CYCLES(FLASH),
    .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .speed(speed),
    .enable_led(enable_led), .all_leds(all_leds), .ready(ready), .done(done),
    .led_green(led_green), .led_red(led_red), .led_blue(led_blue), .led_yellow(led_yellow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] leds;  // {yellow, blue, red, green}
    logic       ready;
    logic       done;
  } exp_t;

  localparam exp_t IDLE_EXP = '{leds: 4'b0000, ready: 1'b1, done: 1'b0};

  exp_t q[$];
  exp_t cur = IDLE_EXP;
  int   total = 0;
  int   bad   = 0;

  task automatic push_off(input int n);
    for (int i = 0; i < n; i++) q.push_back('{leds: 4'b0000, ready: 1'b0, done: 1'b0});
  endtask

  task automatic push_item(input logic [1:0] col, input logic spd);
    logic [3:0] pat;
    pat = 4'(1 << col);
    for (int i = 0; i < (spd ? FAST : SLOW); i++) q.push_back('{leds: pat, ready: 1'b0, done: 1'b0});
    push_off(GAPC);
    q.push_back('{leds: 4'b0000, ready: 1'b1, done: 1'b1});
  endtask

  task automatic push_flash();
    for (int r = 0; r < REPS; r++) begin
      for (int i = 0; i < FLASH; i++) q.push_back('{leds: 4'b1111, ready: 1'b0, done: 1'b0});
      push_off(GAPC);
    end
    q.push_back('{leds: 4'b0000, ready: 1'b1, done: 1'b1});
  endtask

  task automatic step(input string tag, input logic r, input logic en, input logic al,
                      input logic [1:0] col, input logic spd);
    logic [3:0] obs;
    rst_n = r; enable_led = en; all_leds = al; color_in = col; speed = spd;
    @(posedge clk);
    if (!r) begin
      q.delete();
      cur = IDLE_EXP;
    end else begin
      if (cur.ready && (en || al)) begin
        if (al) push_flash();
        else    push_item(col, spd);
      end
      cur = (q.size() > 0) ? q.pop_front() : IDLE_EXP;
    end
    #1;
    obs = {led_yellow, led_blue, led_red, led_green};
    total++;
    assert (obs === cur.leds) else begin
      bad++;
      $error("FAIL %s leds: got %b want %b", tag, obs, cur.leds);
    end
    total++;
    assert (ready === cur.ready) else begin
      bad++;
      $error("FAIL %s ready: got %b want %b", tag, ready, cur.ready);
    end
    total++;
    assert (done === cur.done) else begin
      bad++;
      $error("FAIL %s done: got %b want %b", tag, done, cur.done);
    end
  endtask

  task automatic idle_for(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    // power-up reset
    step("rst0", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    step("rst1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle_for("idle", 2);

    // reset while red is showing
    step("red_acc", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    idle_for("red_on", 2);
    step("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    idle_for("post_rst", 2);

    // blue fast single pulse
    step("blue_acc", 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
    idle_for("blue", 5);

    // red slow with color/speed toggled mid-show
    step("red_acc2", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    step("red_tog1", 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    step("red_tog2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    idle_for("red_rest", 5);

    // both requests together: flash wins
    step("both_acc", 1'b1, 1'b1, 1'b1, 2'b10, 1'b1);
    idle_for("flash", REPS * (FLASH + GAPC) + 2);

    // enable held high: green then yellow back-to-back
    step("hold_g", 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < FAST + GAPC; i++) step("hold_g_busy", 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step("hold_y", 1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
    step("hold_y_on", 1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
    idle_for("hold_y_rest", 4);

    // request pulses while busy are ignored
    step("busy_acc", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step("busy_en", 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    step("busy_gap", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    step("busy_all", 1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
    idle_for("busy_rest", 6);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 79) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
